// File: rtl/i2s_cfg_arbiter_pkg.sv
// Shared types and constants for the serial config-write arbiter.
// Word layout is {addr[5:0], 2'b00, value[7:0]}.
package i2s_cfg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam int CFG_DATA_W = 16;
  localparam int ADDR_W     = 6;
  localparam int VAL_W      = 8;

  function automatic logic [CFG_DATA_W-1:0] cfg_word(input logic [ADDR_W-1:0] addr,
                                                     input logic [VAL_W-1:0]  val);
    return {addr, 2'b00, val};
  endfunction

endpackage

// File: rtl/i2s_cfg_arbiter_if.sv
// Requester and serial-controller side signals of the config-write arbiter.
// The master modport is the arbiter itself; slave is whatever drives it.
interface i2s_cfg_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 16
);
  logic [NREQ-1:0]        iREQ;
  logic [NREQ*DATA_W-1:0] iREQ_DATA;
  logic [NREQ-1:0]        oGNT;
  logic [NREQ-1:0]        oDONE;
  logic                   oERR;
  logic                   oBUSY;
  logic                   oSTR;
  logic [DATA_W-1:0]      oDATA;
  logic                   iRDY;
  logic                   iACK;

  modport master (
    input  iREQ, iREQ_DATA, iRDY, iACK,
    output oGNT, oDONE, oERR, oBUSY, oSTR, oDATA
  );

  modport slave (
    output iREQ, iREQ_DATA, iRDY, iACK,
    input  oGNT, oDONE, oERR, oBUSY, oSTR, oDATA
  );
endinterface

// File: rtl/i2s_cfg_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last
// requester served and wraps, so the lowest rotating offset wins.
module i2s_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);
  localparam int LW = $clog2(NREQ);

  // Walk from the farthest offset down so the nearest requester overwrites.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % NREQ]) begin
        gnt_o                                 = '0;
        gnt_o[(int'(last_i) + k) % NREQ]      = 1'b1;
        idx_o                                 = LW'((int'(last_i) + k) % NREQ);
      end
    end
  end
endmodule

// File: rtl/i2s_cfg_arbiter.sv
// Round-robin arbiter sharing one 3-wire register-write controller between
// NREQ requesters, with NACK retry and a fixed idle gap between transfers.
module i2s_cfg_arbiter
  import i2s_cfg_arbiter_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int DATA_W     = CFG_DATA_W,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic               mI2S_CLK,
  input  logic               iRST_N,
  i2s_cfg_arbiter_if.master  bus
);
  // state    | meaning
  // ST_IDLE  | no transfer; pick a winner when any request is up
  // ST_ISSUE | oSTR high, latched word on oDATA, waiting for iRDY
  // ST_GAP   | oSTR low for the idle gap, then retry or go idle

  localparam int LW = $clog2(NREQ);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              str_q, str_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LW-1:0]     gidx_q, gidx_d;
  logic [LW-1:0]     last_q, last_d;
  logic [RW-1:0]     retry_cnt_q, retry_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              retry_q, retry_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [LW-1:0]     pick_idx;
  logic [DATA_W-1:0] pick_word;

  i2s_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i  (bus.iREQ),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_comb begin
    pick_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == LW'(i)) pick_word = bus.iREQ_DATA[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = 1'b0;
    str_d       = str_q;
    data_d      = data_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    retry_cnt_d = retry_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    retry_d     = retry_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.iREQ) begin
          gnt_d       = pick_gnt;
          gidx_d      = pick_idx;
          data_d      = pick_word;
          str_d       = 1'b1;
          retry_cnt_d = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.iRDY) begin
          str_d     = 1'b0;
          gap_cnt_d = GW'(GAP_CYCLES);
          state_d   = ST_GAP;
          if (bus.iACK) begin
            done_d  = gnt_q;
            gnt_d   = '0;
            last_d  = gidx_q;
            retry_d = 1'b0;
          end else if (retry_cnt_q < RW'(MAX_RETRY)) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            retry_d     = 1'b1;
          end else begin
            done_d  = gnt_q;
            err_d   = 1'b1;
            gnt_d   = '0;
            last_d  = gidx_q;
            retry_d = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          if (retry_q) begin
            str_d   = 1'b1;
            retry_d = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mI2S_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      str_q       <= 1'b0;
      data_q      <= '0;
      gidx_q      <= '0;
      last_q      <= LW'(NREQ - 1);
      retry_cnt_q <= '0;
      gap_cnt_q   <= '0;
      retry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      str_q       <= str_d;
      data_q      <= data_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      retry_cnt_q <= retry_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      retry_q     <= retry_d;
    end
  end

  assign bus.oGNT  = gnt_q;
  assign bus.oDONE = done_q;
  assign bus.oERR  = err_q;
  assign bus.oSTR  = str_q;
  assign bus.oDATA = data_q;
  assign bus.oBUSY = (state_q != ST_IDLE);
endmodule

// File: tb/tb_i2s_cfg_arbiter.sv
// Directed bench for i2s_cfg_arbiter: single write, contention, NACK retry,
// retry exhaustion, data change during transfer and reset mid-transfer.
module tb_i2s_cfg_arbiter;
  import i2s_cfg_arbiter_pkg::*;

  localparam int GAP = 2;

  logic mI2S_CLK;
  logic iRST_N;
  int   n_chk = 0;
  int   n_err = 0;

  int   cyc = 0;
  int   rises = 0;
  int   fall_cyc = 0;
  bit   fall_valid = 0;
  int   min_space = 1000;
  bit   str_prev = 0;

  i2s_cfg_arbiter_if #(.NREQ(2), .DATA_W(16)) bus ();

  i2s_cfg_arbiter #(.NREQ(2), .DATA_W(16), .MAX_RETRY(3), .GAP_CYCLES(GAP)) dut (
    .mI2S_CLK (mI2S_CLK),
    .iRST_N   (iRST_N),
    .bus      (bus.master)
  );

  initial begin
    mI2S_CLK = 1'b0;
    forever #5 mI2S_CLK = ~mI2S_CLK;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and track oSTR rise/fall spacing.
  task automatic tick();
    @(negedge mI2S_CLK);
    cyc++;
    if (bus.oSTR && !str_prev) begin
      rises++;
      if (fall_valid && (cyc - fall_cyc) < min_space) min_space = cyc - fall_cyc;
    end
    if (!bus.oSTR && str_prev) begin
      fall_cyc   = cyc;
      fall_valid = 1'b1;
    end
    str_prev = bus.oSTR;
  endtask

  task automatic clr_mon();
    rises      = 0;
    fall_valid = 1'b0;
    min_space  = 1000;
  endtask

  task automatic wait_str(input string tag);
    for (int i = 0; i < 30 && bus.oSTR !== 1'b1; i++) tick();
    chk({tag, "_str_up"}, 32'(bus.oSTR), 32'd1);
  endtask

  task automatic serve(input int dly, input bit ack, input logic [1:0] exp_gnt,
                       input logic [15:0] exp_data, input logic [1:0] exp_done,
                       input bit exp_err, input string tag);
    bit stable;
    logic [1:0] gnt_after;
    wait_str(tag);
    chk({tag, "_gnt"}, 32'(bus.oGNT), 32'(exp_gnt));
    chk({tag, "_data"}, 32'(bus.oDATA), 32'(exp_data));
    stable = 1'b1;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (bus.oSTR !== 1'b1 || bus.oDATA !== exp_data) stable = 1'b0;
    end
    chk({tag, "_hold"}, 32'(stable), 32'd1);
    bus.iRDY = 1'b1;
    bus.iACK = ack;
    tick();
    bus.iRDY = 1'b0;
    bus.iACK = 1'b0;
    gnt_after = (exp_done != 2'b00) ? 2'b00 : exp_gnt;
    chk({tag, "_str_dn"}, 32'(bus.oSTR), 32'd0);
    chk({tag, "_done"}, 32'(bus.oDONE), 32'(exp_done));
    chk({tag, "_err"}, 32'(bus.oERR), 32'(exp_err));
    chk({tag, "_gnt_after"}, 32'(bus.oGNT), 32'(gnt_after));
    tick();
    chk({tag, "_done_clr"}, 32'({bus.oDONE, bus.oERR}), 32'd0);
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    tick();
    tick();
    iRST_N = 1'b1;
    tick();
  endtask

  initial begin
    iRST_N        = 1'b0;
    bus.iREQ      = 2'b00;
    bus.iREQ_DATA = '0;
    bus.iRDY      = 1'b0;
    bus.iACK      = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 32'(bus.oGNT), 32'd0);
    chk("rst_done", 32'(bus.oDONE), 32'd0);
    chk("rst_err", 32'(bus.oERR), 32'd0);
    chk("rst_busy", 32'(bus.oBUSY), 32'd0);
    chk("rst_str", 32'(bus.oSTR), 32'd0);
    chk("rst_data", 32'(bus.oDATA), 32'd0);
    iRST_N = 1'b1;
    tick();

    // single write, ACK after 20 cycles
    clr_mon();
    bus.iREQ      = 2'b01;
    bus.iREQ_DATA = {16'h0000, 16'h0800};
    tick();
    chk("single_busy", 32'(bus.oBUSY), 32'd1);
    serve(20, 1'b1, 2'b01, 16'h0800, 2'b01, 1'b0, "single");
    bus.iREQ = 2'b00;
    chk("single_pulses", 32'(rises), 32'd1);

    // contention with both requests held, order restarts from 0 after reset
    do_reset();
    clr_mon();
    bus.iREQ      = 2'b11;
    bus.iREQ_DATA = {16'h1422, 16'h0A11};
    serve(3, 1'b1, 2'b01, 16'h0A11, 2'b01, 1'b0, "cont0");
    serve(3, 1'b1, 2'b10, 16'h1422, 2'b10, 1'b0, "cont1");
    serve(5, 1'b1, 2'b01, 16'h0A11, 2'b01, 1'b0, "cont2");
    serve(0, 1'b1, 2'b10, 16'h1422, 2'b10, 1'b0, "cont3");
    bus.iREQ = 2'b00;
    chk("cont_pulses", 32'(rises), 32'd4);
    chk("cont_spacing", 32'(min_space >= GAP + 1), 32'd1);

    // two NACKs then ACK
    clr_mon();
    bus.iREQ      = 2'b01;
    bus.iREQ_DATA = {16'h0000, 16'h2C5A};
    serve(4, 1'b0, 2'b01, 16'h2C5A, 2'b00, 1'b0, "nack0");
    serve(4, 1'b0, 2'b01, 16'h2C5A, 2'b00, 1'b0, "nack1");
    serve(4, 1'b1, 2'b01, 16'h2C5A, 2'b01, 1'b0, "nack2");
    bus.iREQ = 2'b00;
    chk("nack_pulses", 32'(rises), 32'd3);
    chk("nack_spacing", 32'(min_space >= GAP + 1), 32'd1);

    // always NACK: four issues, then DONE with ERR; next request served
    clr_mon();
    bus.iREQ      = 2'b10;
    bus.iREQ_DATA = {16'h3CFF, 16'h0000};
    serve(2, 1'b0, 2'b10, 16'h3CFF, 2'b00, 1'b0, "exh0");
    serve(2, 1'b0, 2'b10, 16'h3CFF, 2'b00, 1'b0, "exh1");
    serve(2, 1'b0, 2'b10, 16'h3CFF, 2'b00, 1'b0, "exh2");
    serve(2, 1'b0, 2'b10, 16'h3CFF, 2'b10, 1'b1, "exh3");
    bus.iREQ      = 2'b01;
    bus.iREQ_DATA = {16'h3CFF, 16'h0401};
    serve(1, 1'b1, 2'b01, 16'h0401, 2'b01, 1'b0, "after_exh");
    bus.iREQ = 2'b00;
    chk("exh_pulses", 32'(rises), 32'd5);
    chk("exh_spacing", 32'(min_space >= GAP + 1), 32'd1);

    // word and request change during the transfer do not disturb it
    bus.iREQ      = 2'b01;
    bus.iREQ_DATA = {16'h0000, 16'h1C34};
    wait_str("chg");
    bus.iREQ_DATA = {16'h0000, 16'h2C99};
    serve(3, 1'b0, 2'b01, 16'h1C34, 2'b00, 1'b0, "chg0");
    bus.iREQ = 2'b00;
    serve(3, 1'b1, 2'b01, 16'h1C34, 2'b01, 1'b0, "chg1");

    // reset in the middle of ISSUE
    bus.iREQ      = 2'b11;
    bus.iREQ_DATA = {16'h0455, 16'h0A66};
    wait_str("mid");
    chk("mid_gnt", 32'(bus.oGNT), 32'd2);
    tick();
    tick();
    #2 iRST_N = 1'b0;
    #1;
    chk("mid_rst_str", 32'(bus.oSTR), 32'd0);
    chk("mid_rst_gnt", 32'(bus.oGNT), 32'd0);
    chk("mid_rst_busy", 32'(bus.oBUSY), 32'd0);
    chk("mid_rst_data", 32'(bus.oDATA), 32'd0);
    chk("mid_rst_done", 32'({bus.oDONE, bus.oERR}), 32'd0);
    tick();
    iRST_N = 1'b1;
    serve(1, 1'b1, 2'b01, 16'h0A66, 2'b01, 1'b0, "post_rst");
    bus.iREQ = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    chk("end_idle", 32'(bus.oBUSY), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/i2s_cfg_arbiter.md
# i2s_cfg_arbiter

Shares one 3-wire serial register-write controller between NREQ independent requesters, for example the power-up LCD config sequencer and a runtime brightness/contrast updater. Requests are granted round-robin. Each granted 16-bit word is driven onto the controller's start/ready/ack handshake, and NACKed writes are retried up to a bounded count. The block sits between the requesters and the serial controller and runs in the controller's clock domain.

## Interface
Parameters:
- NREQ, 2 — number of requesters; range 2–8.
- DATA_W, 16 — width of one register word: {addr[5:0], 2'b0, value[7:0]}.
- MAX_RETRY, 3 — number of re-issues after a NACK before the write is abandoned; range 0–15.
- GAP_CYCLES, 2 — number of idle cycles between consecutive controller transfers; minimum 1.

Ports:
- mI2S_CLK  in  1  serial-controller clock.
- iRST_N  in  1  reset, asynchronous, active-low.
- iREQ  in  NREQ  per-requester request level.
- iREQ_DATA  in  NREQ*DATA_W  per-requester word; requester i occupies bits [i*DATA_W +: DATA_W].
- oGNT  out  NREQ  one-hot grant; high while that requester's write is in progress.
- oDONE  out  NREQ  one-cycle completion pulse to the served requester.
- oERR  out  1  one-cycle pulse, coincident with oDONE, when retries are exhausted.
- oBUSY  out  1  high in every state except IDLE.
- oSTR  out  1  start level to the controller.
- oDATA  out  DATA_W  word to the controller.
- iRDY  in  1  controller transfer complete.
- iACK  in  1  controller acknowledge; valid when iRDY=1.

## Operation
- FSM states are IDLE, ISSUE, GAP.
- IDLE:
  - If any iREQ bit is set, the round-robin picker selects the winner. Search starts at the requester after the last one served; after reset it starts at 0.
  - At the same edge: oGNT is set to the winner, oDATA latches the winner's word, oSTR goes to 1, retry_cnt clears, and the state moves to ISSUE.
- ISSUE:
  - oSTR stays at 1 and oDATA stays stable until iRDY=1 is sampled.
  - At that edge oSTR goes to 0, and one of three outcomes applies:
    - iACK=1: oDONE[g] pulses, oGNT clears, last-served is set to g, and the state moves to GAP with retry=0.
    - iACK=0 and retry_cnt<MAX_RETRY: retry_cnt increments, oGNT is held, and the state moves to GAP with retry=1.
    - iACK=0 and retry_cnt==MAX_RETRY: oDONE[g] and oERR pulse together, oGNT clears, last-served is set to g, and the state moves to GAP with retry=0.
- GAP:
  - The gap counter runs GAP_CYCLES cycles with oSTR=0.
  - On expiry: if retry=1, oSTR goes to 1 with the same latched oDATA and the state moves to ISSUE. Otherwise the state moves to IDLE.
- The word is latched at grant. A requester that changes iREQ_DATA or drops iREQ during its own transfer does not affect that transfer; it still receives oDONE.
- A requester must hold iREQ until it sees oDONE. If iREQ is still high after oDONE, that is a new request.
- iRDY is ignored in IDLE and GAP.
- Counters are sized $clog2(MAX_RETRY+1) for retry_cnt and $clog2(GAP_CYCLES+1) for the gap counter. Neither counter wraps.

## Timing
- Reset values: oGNT=0, oDONE=0, oERR=0, oBUSY=0, oSTR=0, oDATA=0, state=IDLE, last-served=NREQ-1.
- Reset asserted mid-transfer drops oSTR immediately and asynchronously. No oDONE is issued, and the pending request is re-arbitrated after reset.
- If iREQ is seen in IDLE at edge n, then oGNT, oSTR and oDATA are valid after edge n. There is no combinational path from iREQ to any output.
- If iRDY=1 is sampled at edge m, then oDONE/oERR are high for the cycle after m, and oSTR is 0 after m.
- Minimum spacing from one oSTR fall to the next oSTR rise is GAP_CYCLES+1 cycles.
- Simultaneous requests are served one per transfer in rotating order. No requester waits behind more than NREQ-1 other transfers.
- A controller that returns iRDY=1 in the first ISSUE cycle is legal; that gives a single-cycle ISSUE.

## Structure
- A shared package holds the state enum (IDLE/ISSUE/GAP), the default DATA_W, and the field-layout constants ADDR_W=6 and VAL_W=8.
- One sub-module, i2s_rr_pick: combinational round-robin picker. Inputs are req[NREQ] and last[clog2]. Outputs are one-hot gnt and an index.
- The top module holds the FSM, the latches and the counters.

## Test plan
- Single write: iREQ=01, data0=16'h0800; controller model returns iRDY/iACK=1 after 20 cycles → one STR pulse carrying 16'h0800, then oDONE=01 one cycle after iRDY, oERR=0.
- Contention: iREQ=11 held, both ACK → grants in order 01, 10, 01, 10; consecutive STR rises are at least GAP_CYCLES+1 cycles apart after the preceding fall.
- NACK retry: the model NACKs twice then ACKs, MAX_RETRY=3 → 3 STR pulses with identical oDATA, a single oDONE, oERR=0.
- Retry exhaustion: always NACK, MAX_RETRY=3 → 4 STR pulses, then oDONE and oERR pulse together; the next request is then served normally.
- Data change during transfer: iREQ_DATA changed while in ISSUE → oDATA keeps the latched word through the retries.
- Reset mid-ISSUE: iRST_N pulsed low → oSTR=0 immediately, all outputs at reset values; with iREQ still held, a fresh grant goes to requester 0.
